// File: rtl/gtxe2_chnl_rx_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gtxe2_chnl_rx_align_ctrl
// Brief   : RX comma-aligner sequencer with an IDLE/HUNT/ACQ/LOCKED sync FSM,
//           code-error loss tracking, comma timeout and a realign counter.
// Revision: 1.0 - initial release
// ============================================================================
module gtxe2_chnl_rx_align_ctrl #(
  parameter int    ACQ_COMMAS    = 4,
  parameter int    LOSS_ERRORS   = 4,
  parameter int    GOOD_RECOVER  = 4,
  parameter int    COMMA_TIMEOUT = 1024,
  parameter string PCOMMA_EN     = "TRUE",
  parameter string MCOMMA_EN     = "TRUE",
  parameter string LOCK_ALIGN    = "TRUE",
  parameter int    CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxelecidle,
  input  logic             rxbyteisaligned,
  input  logic             rxbyterealign,
  input  logic             rxcommadet,
  input  logic             rx_err,
  input  logic             cnt_clr,
  output logic             RXCOMMADETEN,
  output logic             RXPCOMMAALIGNEN,
  output logic             RXMCOMMAALIGNEN,
  output logic             sync_ok,
  output logic             sync_lost,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] realign_cnt
);

  localparam logic c_P_EN      = (PCOMMA_EN == "TRUE");
  localparam logic c_M_EN      = (MCOMMA_EN == "TRUE");
  localparam logic c_LOCK_FRZ  = (LOCK_ALIGN == "TRUE");

  localparam int c_CC_W  = $clog2(ACQ_COMMAS + 1);
  localparam int c_ERR_W = $clog2(LOSS_ERRORS + 1);
  localparam int c_GR_W  = $clog2(GOOD_RECOVER + 1);
  localparam int c_TMR_W = $clog2(COMMA_TIMEOUT + 1);

  localparam logic [c_CC_W-1:0]  c_CC_LAST  = c_CC_W'(ACQ_COMMAS - 1);
  localparam logic [c_ERR_W-1:0] c_ERR_LAST = c_ERR_W'(LOSS_ERRORS - 1);
  localparam logic [c_GR_W-1:0]  c_GR_LAST  = c_GR_W'(GOOD_RECOVER - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(COMMA_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HUNT   = 2'd1,
    S_ACQ    = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_sync_lost;
  logic [c_CC_W-1:0]  r_comma_cnt;
  logic [c_ERR_W-1:0] r_err_cnt;
  logic [c_GR_W-1:0]  r_good_run;
  logic [c_TMR_W-1:0] r_timer;
  logic [CNT_W-1:0]   r_realign_cnt;
  logic               w_timer_hit;
  logic               w_tracking;

  assign w_tracking  = (r_state == S_ACQ) || (r_state == S_LOCKED);
  assign w_timer_hit = w_tracking && !rxcommadet && (r_timer == c_TMR_LAST);

  // Next-state: elecidle overrides everything; within LOCKED, error loss
  // is checked ahead of the comma timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        w_next = S_HUNT;
      end
      S_HUNT: begin
        if (rxcommadet && rxbyteisaligned)
          w_next = (ACQ_COMMAS == 1) ? S_LOCKED : S_ACQ;
      end
      S_ACQ: begin
        if (rx_err)
          w_next = S_HUNT;
        else if (rxcommadet && (r_comma_cnt == c_CC_LAST))
          w_next = S_LOCKED;
        else if (w_timer_hit)
          w_next = S_HUNT;
      end
      S_LOCKED: begin
        if (rx_err && (r_err_cnt == c_ERR_LAST))
          w_next = S_HUNT;
        else if (w_timer_hit)
          w_next = S_HUNT;
      end
      default: w_next = S_IDLE;
    endcase
    if (rxelecidle)
      w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sync_lost   <= 1'b0;
      r_comma_cnt   <= '0;
      r_err_cnt     <= '0;
      r_good_run    <= '0;
      r_timer       <= '0;
      r_realign_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_sync_lost <= (r_state == S_LOCKED) && (w_next != S_LOCKED);

      // Idle timer restarts on any state change or comma.
      if ((w_next != r_state) || rxcommadet || !w_tracking)
        r_timer <= '0;
      else
        r_timer <= r_timer + c_TMR_W'(1);

      if (r_state == S_HUNT)
        r_comma_cnt <= c_CC_W'(1);
      else if ((r_state == S_ACQ) && rxcommadet)
        r_comma_cnt <= r_comma_cnt + c_CC_W'(1);

      // Leaky error bucket, only active while locked.
      if (r_state != S_LOCKED) begin
        r_err_cnt  <= '0;
        r_good_run <= '0;
      end else if (rx_err) begin
        r_err_cnt  <= r_err_cnt + c_ERR_W'(1);
        r_good_run <= '0;
      end else if (r_good_run == c_GR_LAST) begin
        r_good_run <= '0;
        if (r_err_cnt != '0)
          r_err_cnt <= r_err_cnt - c_ERR_W'(1);
      end else begin
        r_good_run <= r_good_run + c_GR_W'(1);
      end

      if (cnt_clr)
        r_realign_cnt <= '0;
      else if (rxbyterealign && RXCOMMADETEN && (r_realign_cnt != {CNT_W{1'b1}}))
        r_realign_cnt <= r_realign_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    RXCOMMADETEN    = 1'b0;
    RXPCOMMAALIGNEN = 1'b0;
    RXMCOMMAALIGNEN = 1'b0;
    sync_ok         = 1'b0;
    case (r_state)
      S_HUNT, S_ACQ: begin
        RXCOMMADETEN    = 1'b1;
        RXPCOMMAALIGNEN = c_P_EN;
        RXMCOMMAALIGNEN = c_M_EN;
      end
      S_LOCKED: begin
        RXCOMMADETEN    = 1'b1;
        RXPCOMMAALIGNEN = c_P_EN && !c_LOCK_FRZ;
        RXMCOMMAALIGNEN = c_M_EN && !c_LOCK_FRZ;
        sync_ok         = 1'b1;
      end
      default: ;
    endcase
  end

  assign sync_lost   = r_sync_lost;
  assign state       = r_state;
  assign realign_cnt = r_realign_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gtxe2_chnl_rx_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_gtxe2_chnl_rx_align_ctrl
// Brief   : Directed self-checking bench for the RX align sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gtxe2_chnl_rx_align_ctrl;

  logic        clk = 1'b0;
  logic        rst, rxelecidle, rxbyteisaligned, rxbyterealign, rxcommadet, rx_err, cnt_clr;
  logic        detEn, pEn, mEn, ok, lost;
  logic [1:0]  st;
  logic [15:0] rcnt;
  logic        detEn2, pEn2, mEn2, ok2, lost2;
  logic [1:0]  st2;
  logic [1:0]  rcnt2;
  integer      total = 0;
  integer      bad   = 0;

  always #5 clk = ~clk;

  gtxe2_chnl_rx_align_ctrl u_dut (
    .clk(clk), .rst(rst), .rxelecidle(rxelecidle), .rxbyteisaligned(rxbyteisaligned),
    .rxbyterealign(rxbyterealign), .rxcommadet(rxcommadet), .rx_err(rx_err), .cnt_clr(cnt_clr),
    .RXCOMMADETEN(detEn), .RXPCOMMAALIGNEN(pEn), .RXMCOMMAALIGNEN(mEn),
    .sync_ok(ok), .sync_lost(lost), .state(st), .realign_cnt(rcnt)
  );

  gtxe2_chnl_rx_align_ctrl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .rxelecidle(rxelecidle), .rxbyteisaligned(rxbyteisaligned),
    .rxbyterealign(rxbyterealign), .rxcommadet(rxcommadet), .rx_err(rx_err), .cnt_clr(cnt_clr),
    .RXCOMMADETEN(detEn2), .RXPCOMMAALIGNEN(pEn2), .RXMCOMMAALIGNEN(mEn2),
    .sync_ok(ok2), .sync_lost(lost2), .state(st2), .realign_cnt(rcnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Four back-to-back aligned commas from HUNT; ends in LOCKED with comma low.
  task automatic goto_locked();
    rxcommadet = 1'b1; rxbyteisaligned = 1'b1;
    repeat (4) step();
    rxcommadet = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rxelecidle = 1'b0; rxbyteisaligned = 1'b0; rxbyterealign = 1'b0;
    rxcommadet = 1'b0; rx_err = 1'b0; cnt_clr = 1'b0;
    repeat (3) step();
    total++; if (st !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st); end
    total++; if ({detEn, pEn, mEn, ok, lost} !== 5'b0) begin bad++; $display("FAIL reset_outs got=%b exp=00000", {detEn, pEn, mEn, ok, lost}); end
    total++; if (rcnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", rcnt); end
    rst = 1'b0;
    step();
    total++; if (st !== 2'd1) begin bad++; $display("FAIL idle_to_hunt got=%0d exp=1", st); end
    total++; if ({detEn, pEn, mEn, ok} !== 4'b1110) begin bad++; $display("FAIL hunt_enables got=%b exp=1110", {detEn, pEn, mEn, ok}); end
  endtask

  task automatic test_lock();
    rxbyteisaligned = 1'b1;
    rxcommadet = 1'b1; step();
    total++; if (st !== 2'd2) begin bad++; $display("FAIL hunt_to_acq got=%0d exp=2", st); end
    rxcommadet = 1'b0; repeat (2) step();
    rxcommadet = 1'b1; step();
    rxcommadet = 1'b0; step();
    rxcommadet = 1'b1; step();
    total++; if (st !== 2'd2) begin bad++; $display("FAIL acq_after3 got=%0d exp=2", st); end
    rxcommadet = 1'b0; step();
    rxcommadet = 1'b1; step();
    rxcommadet = 1'b0;
    total++; if (st !== 2'd3) begin bad++; $display("FAIL locked_after4 got=%0d exp=3", st); end
    total++; if ({detEn, pEn, mEn, ok} !== 4'b1001) begin bad++; $display("FAIL locked_enables got=%b exp=1001", {detEn, pEn, mEn, ok}); end
  endtask

  task automatic test_err_loss();
    for (int i = 0; i < 3; i++) begin
      rx_err = 1'b1; step();
      rx_err = 1'b0; step();
    end
    total++; if ((st !== 2'd3) || (lost !== 1'b0)) begin bad++; $display("FAIL after3err got st=%0d lost=%b exp st=3 lost=0", st, lost); end
    rx_err = 1'b1; step(); rx_err = 1'b0;
    total++; if ((st !== 2'd1) || (lost !== 1'b1)) begin bad++; $display("FAIL err_loss got st=%0d lost=%b exp st=1 lost=1", st, lost); end
    step();
    total++; if (lost !== 1'b0) begin bad++; $display("FAIL lost_pulse_width got=%b exp=0", lost); end
  endtask

  task automatic test_err_recover();
    goto_locked();
    for (int i = 0; i < 6; i++) begin
      rx_err = 1'b1; step();
      rx_err = 1'b0; repeat (4) step();
      total++; if (st !== 2'd3) begin bad++; $display("FAIL spaced_err_%0d got=%0d exp=3", i, st); end
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    rxcommadet = 1'b1; step(); rxcommadet = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (st != 2'd3) break;
      step();
      n++;
    end
    total++; if (n !== 1024) begin bad++; $display("FAIL timeout_cycles got=%0d exp=1024", n); end
    total++; if ((st !== 2'd1) || (lost !== 1'b1)) begin bad++; $display("FAIL timeout_exit got st=%0d lost=%b exp st=1 lost=1", st, lost); end
    rxcommadet = 1'b1; step(); rxcommadet = 1'b0;
    total++; if (st !== 2'd2) begin bad++; $display("FAIL reacq got=%0d exp=2", st); end
    rxelecidle = 1'b1; step();
    total++; if ((st !== 2'd0) || ({detEn, pEn, mEn} !== 3'b000)) begin bad++; $display("FAIL acq_elecidle got st=%0d en=%b exp st=0 en=000", st, {detEn, pEn, mEn}); end
    rxelecidle = 1'b0; step();
  endtask

  task automatic test_back_to_back();
    // rx_err and comma together in ACQ: error wins
    rxcommadet = 1'b1; step();
    rx_err = 1'b1; step();
    rx_err = 1'b0; rxcommadet = 1'b0;
    total++; if (st !== 2'd1) begin bad++; $display("FAIL acq_err_wins got=%0d exp=1", st); end
    goto_locked();
    rxelecidle = 1'b1; rx_err = 1'b1; step();
    rxelecidle = 1'b0; rx_err = 1'b0;
    total++; if ((st !== 2'd0) || (lost !== 1'b1)) begin bad++; $display("FAIL lock_elecidle got st=%0d lost=%b exp st=0 lost=1", st, lost); end
    step();
  endtask

  task automatic test_realign();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    rxbyterealign = 1'b1; repeat (5) step();
    total++; if (rcnt !== 16'd5) begin bad++; $display("FAIL realign_cnt16 got=%0d exp=5", rcnt); end
    total++; if (rcnt2 !== 2'd3) begin bad++; $display("FAIL realign_sat got=%0d exp=3", rcnt2); end
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    total++; if ((rcnt !== 16'd0) || (rcnt2 !== 2'd0)) begin bad++; $display("FAIL clr_wins got=%0d/%0d exp=0/0", rcnt, rcnt2); end
    rxbyterealign = 1'b0; rxelecidle = 1'b1; step();
    rxbyterealign = 1'b1; repeat (2) step();
    rxbyterealign = 1'b0;
    total++; if (rcnt !== 16'd0) begin bad++; $display("FAIL realign_idle got=%0d exp=0", rcnt); end
    rxelecidle = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_err_loss();
    test_err_recover();
    test_timeout();
    test_back_to_back();
    test_realign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
